// File: rtl/data_mem_resp.sv
// Data memory with a fixed access latency, answering CPU load/store requests
// with a stall/done/err handshake.
module data_mem_resp #(
    parameter int LATENCY = 3,
    parameter int DEPTH   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wr_data_i,
    input  logic        mem_wr_i,
    input  logic        mem_rd_i,
    output logic [31:0] rd_data_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          wr_q;
    logic          err_q;
    logic [31:0]   rd_data_q;
    logic [31:0]   mem_q [DEPTH];

    logic req;
    logic bad;
    logic accept;
    logic commit;

    assign req    = mem_rd_i | mem_wr_i;
    assign bad    = (mem_rd_i & mem_wr_i) | (addr_i[1:0] != 2'b00) | (addr_i >= LIMIT);
    assign accept = (state_q == IDLE) & req;
    assign commit = (state_q == BUSY) & (cnt_q == 4'd0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall is gated by reset so a CPU request held through reset is not stalled.
    always_comb begin
        stall_o = 1'b0;
        done_o  = 1'b0;
        err_o   = 1'b0;
        case (state_q)
            IDLE: stall_o = rst_i & req;
            BUSY: stall_o = rst_i;
            DONE: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            idx_q     <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            if (accept) begin
                idx_q   <= addr_i[AW+1:2];
                wdata_q <= wr_data_i;
                wr_q    <= mem_wr_i;
                err_q   <= bad;
                if (bad) begin
                    rd_data_q <= '0;
                end
            end
            if (commit) begin
                if (wr_q) begin
                    mem_q[idx_q] <= wdata_q;
                end else begin
                    rd_data_q <= mem_q[idx_q];
                end
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: one instance with LATENCY=3, one with
// LATENCY=1, both DEPTH=32, checked against a per-request behavioural model.
module tb_data_mem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rstN;
    logic [1:0]       rd;
    logic [1:0]       wr;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0][31:0] rdData;
    logic [1:0]       stall;
    logic [1:0]       done;
    logic [1:0]       err;

    int checks   = 0;
    int failures = 0;

    int          latOf [2];
    logic [31:0] refMem [2][32];
    logic [31:0] refRd [2];

    data_mem_resp #(.LATENCY(3), .DEPTH(32)) dut3 (
        .clk_i(clk), .rst_i(rstN[0]), .addr_i(addr[0]), .wr_data_i(wdata[0]),
        .mem_wr_i(wr[0]), .mem_rd_i(rd[0]), .rd_data_o(rdData[0]),
        .stall_o(stall[0]), .done_o(done[0]), .err_o(err[0])
    );

    data_mem_resp #(.LATENCY(1), .DEPTH(32)) dut1 (
        .clk_i(clk), .rst_i(rstN[1]), .addr_i(addr[1]), .wr_data_i(wdata[1]),
        .mem_wr_i(wr[1]), .mem_rd_i(rd[1]), .rd_data_o(rdData[1]),
        .stall_o(stall[1]), .done_o(done[1]), .err_o(err[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clearModel(input int d);
        for (int i = 0; i < 32; i++) begin
            refMem[d][i] = 32'h0;
        end
        refRd[d] = 32'h0;
    endtask

    // One CPU access: the request is held until done_o, optionally with
    // address/data scrambled after the accept cycle.
    task automatic applyStimulus(input int d, input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] wd, input bit toggle);
        logic bad;
        int   expCyc;
        int   stallCnt;
        int   doneCyc;
        bad    = (r && w) || (a[1:0] != 2'b00) || (a >= 32'd128);
        expCyc = bad ? 1 : latOf[d] + 1;
        if (bad) begin
            refRd[d] = 32'h0;
        end else if (w) begin
            refMem[d][a[6:2]] = wd;
        end else begin
            refRd[d] = refMem[d][a[6:2]];
        end
        @(negedge clk);
        rd[d]    = r;
        wr[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
        stallCnt = 0;
        doneCyc  = -1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (toggle) begin
                    addr[d]  = $urandom;
                    wdata[d] = $urandom;
                end
            end
            #1;
            if (stall[d]) stallCnt++;
            if (done[d]) begin
                doneCyc = c;
                break;
            end
        end
        checkOutput($sformatf("d%0d_done_cycle@%h", d, a), doneCyc, expCyc);
        checkOutput($sformatf("d%0d_stall_cycles@%h", d, a), stallCnt, expCyc);
        checkOutput($sformatf("d%0d_err@%h", d, a), {31'b0, err[d]}, {31'b0, bad});
        checkOutput($sformatf("d%0d_rd_data@%h", d, a), rdData[d], refRd[d]);
    endtask

    task automatic idleCheck(input int d);
        @(negedge clk);
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        #1;
        checkOutput($sformatf("d%0d_idle_stall", d), {31'b0, stall[d]}, 32'h0);
        checkOutput($sformatf("d%0d_idle_done", d), {31'b0, done[d]}, 32'h0);
        checkOutput($sformatf("d%0d_idle_err", d), {31'b0, err[d]}, 32'h0);
        checkOutput($sformatf("d%0d_idle_rd_data", d), rdData[d], refRd[d]);
    endtask

    task automatic randomTraffic(input int d, input int n);
        int          kind;
        logic        r;
        logic        w;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            kind = $urandom_range(0, 9);
            r    = 1'($urandom_range(0, 1));
            w    = ~r;
            a    = 32'($urandom_range(0, 31)) << 2;
            if (kind == 0) a = a + 32'($urandom_range(1, 3));
            if (kind == 1) a = 32'd128 + 32'($urandom_range(0, 100000));
            if (kind == 2) begin
                r = 1'b1;
                w = 1'b1;
            end
            applyStimulus(d, r, w, a, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idleCheck(d);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        latOf[0] = 3;
        latOf[1] = 1;
        clearModel(0);
        clearModel(1);
        rstN  = 2'b00;
        rd    = 2'b00;
        wr    = 2'b00;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);

        // A request held during reset must not raise stall.
        rd = 2'b11;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("d%0d_reset_stall", d), {31'b0, stall[d]}, 32'h0);
            checkOutput($sformatf("d%0d_reset_done", d), {31'b0, done[d]}, 32'h0);
            checkOutput($sformatf("d%0d_reset_err", d), {31'b0, err[d]}, 32'h0);
            checkOutput($sformatf("d%0d_reset_rd_data", d), rdData[d], 32'h0);
        end
        rd = 2'b00;
        @(posedge clk);
        #2 rstN = 2'b11;

        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        idleCheck(0);

        applyStimulus(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0);
        idleCheck(0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        applyStimulus(0, 1'b0, 1'b1, 32'h08, 32'hCAFEF00D, 1'b1);
        idleCheck(0);
        applyStimulus(0, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0);
        idleCheck(0);

        randomTraffic(0, 60);
        idleCheck(0);

        // Store to 0x04 aborted by reset in its second BUSY cycle.
        @(negedge clk);
        wr[0]    = 1'b1;
        addr[0]  = 32'h04;
        wdata[0] = 32'h55AA55AA;
        repeat (2) @(negedge clk);
        rstN[0] = 1'b0;
        #1;
        checkOutput("d0_abort_stall", {31'b0, stall[0]}, 32'h0);
        checkOutput("d0_abort_done", {31'b0, done[0]}, 32'h0);
        checkOutput("d0_abort_rd_data", rdData[0], 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checkOutput("d0_abort_hold_done", {31'b0, done[0]}, 32'h0);
            checkOutput("d0_abort_hold_stall", {31'b0, stall[0]}, 32'h0);
        end
        wr[0] = 1'b0;
        clearModel(0);
        @(posedge clk);
        #2 rstN[0] = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        idleCheck(0);

        applyStimulus(1, 1'b0, 1'b1, 32'h00, 32'hA5A5_0001, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 32'h7C, 32'h5A5A_007C, 1'b0);
        idleCheck(1);
        applyStimulus(1, 1'b1, 1'b0, 32'h00, 32'h0, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 32'h7C, 32'h0, 1'b0);
        idleCheck(1);

        randomTraffic(1, 60);
        idleCheck(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter LATENCY, default 3, meaning the number of BUSY cycles per access (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning the number of 32-bit storage words (power of two, 4..1024).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port addr_i, input, 32 bits: byte address of the CPU data request.
REQ-006 The block SHALL have port wr_data_i, input, 32 bits: store data.
REQ-007 The block SHALL have port mem_wr_i, input, 1 bit: store request.
REQ-008 The block SHALL have port mem_rd_i, input, 1 bit: load request.
REQ-009 The block SHALL have port rd_data_o, output, 32 bits: load result.
REQ-010 The block SHALL have port stall_o, output, 1 bit: high means the CPU holds its pipeline and request.
REQ-011 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port err_o, output, 1 bit: qualifies done_o; high means the request was rejected.

Function
REQ-013 The block SHALL implement a DEPTH x 32 storage array, word index addr_i[log2(DEPTH)+1:2].
REQ-014 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 In IDLE, the block SHALL treat mem_rd_i|mem_wr_i high as a request and latch addr_i, wr_data_i and the operation at the clock edge.
REQ-016 A request SHALL be invalid if any of the following holds: mem_rd_i and mem_wr_i are both high; addr_i[1:0] != 0; addr_i >= DEPTH*4.
REQ-017 For a valid request, IDLE SHALL go to BUSY with the down-counter loaded to LATENCY-1.
REQ-018 In BUSY, the counter SHALL decrement each cycle.
REQ-019 In BUSY with counter == 0, the next edge SHALL commit the store or register the load word into rd_data_o, and go to DONE.
REQ-020 For an invalid request, IDLE SHALL go directly to DONE with err_o set; there is no array access and rd_data_o is set to 0.
REQ-021 DONE SHALL last exactly one cycle with done_o=1 and stall_o=0, then return to IDLE.
REQ-022 Requests present during DONE SHALL be ignored, since they are the completed request still held by the CPU.
REQ-023 stall_o SHALL be combinational, equal to (IDLE & request) | BUSY.
REQ-024 For a valid request, stall_o SHALL be high for exactly LATENCY+1 cycles and done_o SHALL appear in cycle T0+LATENCY+1, where T0 is the accept cycle.
REQ-025 For an invalid request, stall_o SHALL be high for 1 cycle and done_o/err_o SHALL appear at T0+1.
REQ-026 rd_data_o SHALL hold its value until the next load completes or an error occurs; stores SHALL not change rd_data_o.
REQ-027 err_o SHALL be low outside DONE.
REQ-028 Input changes during BUSY SHALL have no effect, because the latched copies are used.
REQ-029 Back-to-back requests SHALL be permitted: IDLE in the cycle after DONE accepts a new request.

Reset
REQ-030 When rst_i is low, the block SHALL asynchronously force state=IDLE, counter=0, rd_data_o=0, done_o=0, err_o=0 and all array words=0.
REQ-031 stall_o SHALL be 0 while rst_i is low, regardless of the request inputs.
REQ-032 Reset asserted mid-BUSY SHALL abort the access with no array write and no done_o pulse.
REQ-033 After rst_i deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-034 The bench SHALL cover: store 0xDEADBEEF to 0x10, LATENCY=3 -> stall_o high 4 cycles, done_o=1 and err_o=0 in the 5th cycle, then load 0x10 -> rd_data_o=0xDEADBEEF with done_o.
REQ-035 The bench SHALL cover: load from 0x20 straight after reset -> rd_data_o=0x00000000, err_o=0.
REQ-036 The bench SHALL cover: load 0x13 (misaligned), 0x80 with DEPTH=32 (out of range), and mem_rd_i=mem_wr_i=1 -> 1 stall cycle each, done_o=err_o=1, rd_data_o=0, and the array unchanged.
REQ-037 The bench SHALL cover: a store to 0x04 with rst_i pulled low in the 2nd BUSY cycle -> no done_o, stall_o=0, and a later load of 0x04 returns 0.
REQ-038 The bench SHALL cover: addr_i/wr_data_i toggled during BUSY -> the originally latched address and data are written.
REQ-039 The bench SHALL cover: LATENCY=1 with back-to-back loads of 0x00 and 0x7C -> each stalls 2 cycles and yields done_o with the correct data, and the DONE-cycle request is not re-accepted.
